// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops (add, sub, and, or, slt) produce a registered result one
// edge after acceptance. Unsupported codes produce result 0 with zero set.
// Optional feature macro: ALU_MUL_EN adds code 6, an iterative shift-add
// multiply (low WIDTH bits of a*b) taking WIDTH cycles.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLT = 4'd5;

  // Single-cycle operation evaluation; every unlisted code yields zero.
  function automatic logic [WIDTH-1:0] alu_eval(
    input logic [3:0]       ctrl,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic        [WIDTH-1:0] res;
    sa  = a;
    sb  = b;
    res = '0;
    case (ctrl)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, (sa < sb)};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Output slot state and handshake qualifiers
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [TAG_W-1:0] r_out_tag;

  logic             w_accept;
  logic             w_pop;
  logic             w_slot_free;
  logic             w_load;
  logic [WIDTH-1:0] w_load_val;
  logic [TAG_W-1:0] w_load_tag;
  logic [WIDTH-1:0] w_alu_val;

  assign w_pop       = r_out_valid & out_ready;
  assign w_slot_free = ~r_out_valid | out_ready;
  assign w_accept    = in_valid & in_ready;
  assign w_alu_val   = alu_eval(alu_ctrl, src_a, src_b);

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd6;
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           r_state;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [TAG_W-1:0] r_mul_tag;

  logic             w_is_mul;
  logic             w_start_mul;
  logic             w_load_single;
  logic             w_last;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_acc_next;

  assign w_is_mul      = (alu_ctrl == OP_MUL);
  assign w_start_mul   = w_accept & w_is_mul;
  assign w_load_single = w_accept & ~w_is_mul;
  assign w_last        = (r_cnt == CNT_LAST);
  // The final partial product is folded in on the completing edge itself,
  // so completion needs no extra cycle and a held completion simply
  // re-presents the same sum until the slot frees.
  assign w_acc_next    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_done    = (r_state == S_MUL) & w_last & w_slot_free;

  assign w_load     = w_load_single | w_mul_done;
  assign w_load_val = w_mul_done ? w_acc_next : w_alu_val;
  assign w_load_tag = w_mul_done ? r_mul_tag  : in_tag;
  assign in_ready   = rst_n & (r_state == S_IDLE) & w_slot_free;
  assign busy       = r_busy;

  // Multiplier FSM: one multiplier bit per cycle, holds at the last step if the slot is occupied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_mul_tag <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_mul) begin
            r_state   <= S_MUL;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_mcand   <= src_a;
            r_mplier  <= src_b;
            r_acc     <= '0;
            r_mul_tag <= in_tag;
          end
        end
        S_MUL: begin
          if (!w_last) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
          end else if (w_slot_free) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign w_load     = w_accept;
  assign w_load_val = w_alu_val;
  assign w_load_tag = in_tag;
  assign in_ready   = rst_n & w_slot_free;
  assign busy       = 1'b0;
`endif

  // Output slot: load on accept or multiply completion, otherwise empty on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_out_tag   <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_load_val;
      r_zero      <= (w_load_val == '0);
      r_out_tag   <= w_load_tag;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_alu_exec_unit.sv
`timescale 1ns/1ps
module tb_alu_exec_unit;

  localparam int W = 32;
  localparam int T = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic [T-1:0] in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic [T-1:0] out_tag;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic [T-1:0] tag;
  } exp_t;

  exp_t exp_q[$];

  alu_exec_unit #(.WIDTH(W), .TAG_W(T)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the architectural meaning of each ALUCtrl code.
  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [T-1:0] t);
    exp_t e;
    logic [63:0] prod;
    prod  = {32'b0, a} * {32'b0, b};
    e.res = '0;
    case (c)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      4'd6: e.res = prod[W-1:0];
`endif
      default: e.res = '0;
    endcase
    e.z   = (e.res == 0);
    e.tag = t;
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: record accepts, compare every pop in order, and check held outputs stay put.
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_res;
  logic         hold_z;
  logic [T-1:0] hold_tag;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_result", result, hold_res);
        chk("hold_zero", zero, hold_z);
        chk("hold_tag", out_tag, hold_tag);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", result, e.res);
          chk("sb_zero", zero, e.z);
          chk("sb_tag", out_tag, e.tag);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(alu_ctrl, src_a, src_b, in_tag));
      hold_v   = out_valid && !out_ready;
      hold_res = result;
      hold_z   = zero;
      hold_tag = out_tag;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operation and wait (bounded) until it is accepted.
  task automatic send(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [T-1:0] t);
    int n;
    alu_ctrl = c; src_a = a; src_b = b; in_tag = t; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] c;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctrl = '0; src_a = '0; src_b = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_tag", out_tag, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    step();
    rst_n = 1'b1;

    send(4'd0, 32'd5, 32'd7, 5'd3);
    @(negedge clk);
    chk("add_valid", out_valid, 1'b1);
    chk("add_result", result, 32'd12);
    chk("add_zero", zero, 1'b0);
    chk("add_tag", out_tag, 5'd3);
    step();

    send(4'd1, 32'd0, 32'd1, 5'd1);
    @(negedge clk);
    chk("sub_wrap", result, 32'hFFFF_FFFF);
    chk("sub_wrap_zero", zero, 1'b0);
    step();
    send(4'd1, 32'd9, 32'd9, 5'd2);
    @(negedge clk);
    chk("sub_eq", result, 32'h0);
    chk("sub_eq_zero", zero, 1'b1);
    step();
    send(4'd5, 32'hFFFF_FFFF, 32'd1, 5'd4);
    @(negedge clk);
    chk("slt_neg", result, 32'd1);
    step();
    send(4'd5, 32'd1, 32'hFFFF_FFFF, 5'd5);
    @(negedge clk);
    chk("slt_pos", result, 32'd0);
    step();
    send(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6);
    @(negedge clk);
    chk("and", result, 32'h00F0_00F0);
    step();
    send(4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd7);
    @(negedge clk);
    chk("or", result, 32'hFFF0_FFF0);
    step();
    send(4'd9, 32'd3, 32'd4, 5'd9);
    @(negedge clk);
    chk("unsup_valid", out_valid, 1'b1);
    chk("unsup_result", result, 32'h0);
    chk("unsup_zero", zero, 1'b1);
    step();

    // Backpressure then full-throughput drain
    out_ready = 1'b0;
    send(4'd0, 32'd4, 32'd4, 5'd10);
    alu_ctrl = 4'd0; src_a = 32'd10; src_b = 32'd20; in_tag = 5'd11; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_result", result, 32'd8);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1'b1);
    step();
    for (int k = 0; k < 6; k++) begin
      alu_ctrl = 4'($urandom_range(0, 3)); src_a = $urandom; src_b = $urandom;
      in_tag = 5'(k); in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_ready", in_ready, 1'b1);
      chk("b2b_valid", out_valid, 1'b1);
      step();
    end
    in_valid = 1'b0;
    step();

`ifdef ALU_MUL_EN
    send(4'd6, 32'd6, 32'd7, 5'd12);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("mul_busy", busy, 1'b1);
      chk("mul_in_ready", in_ready, 1'b0);
      chk("mul_not_valid", out_valid, 1'b0);
    end
    @(negedge clk);
    chk("mul_valid", out_valid, 1'b1);
    chk("mul_result", result, 32'd42);
    chk("mul_done_busy", busy, 1'b0);
    step();
    send(4'd6, 32'd6, 32'd7, 5'd13);
    repeat (5) step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mulrst_valid", out_valid, 1'b0);
    chk("mulrst_busy", busy, 1'b0);
    chk("mulrst_ready", in_ready, 1'b0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      chk("mulrst_no_result", out_valid, 1'b0);
    end
    chk("mulrst_busy_after", busy, 1'b0);
    step();
`else
    send(4'd6, 32'd6, 32'd7, 5'd12);
    @(negedge clk);
    chk("code6_valid", out_valid, 1'b1);
    chk("code6_result", result, 32'h0);
    chk("code6_zero", zero, 1'b1);
    chk("code6_busy", busy, 1'b0);
    step();
`endif

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      c = 4'($urandom_range(0, 15));
      if (c == 4'd6 && $urandom_range(0, 3) != 0) c = 4'd0;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      alu_ctrl  = c;
      src_a     = pick();
      src_b     = pick();
      in_tag    = 5'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (W + 8) step();
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
